// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and helpers for the streaming index decoder.
package decoder_pkg;
  localparam int IDX_W_DEF = 2;
  localparam int CNT_W_DEF = 8;
  localparam int OUT_W_DEF = 1 << IDX_W_DEF;
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction
endpackage

// File: rtl/fifo2_sync.sv
// fifo2_sync: two-entry synchronous FIFO with 1-bit wrapping pointers.
module fifo2_sync #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;
  assign full    = cnt_q == 2'd2;
  assign empty   = cnt_q == 2'd0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign cnt_d   = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem_q[wr_q] <= din;
    if (rst) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_q ^ do_push;
      rd_q  <= rd_q ^ do_pop;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/decoder_2to4_stream.sv
// decoder_2to4_stream: buffered index-to-one-hot stream decoder with saturating per-line hit counters.
module decoder_2to4_stream #(
  parameter int IDX_W = decoder_pkg::IDX_W_DEF,
  parameter int CNT_W = decoder_pkg::CNT_W_DEF,
  localparam int OUT_W = 1 << IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       in_idx,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       out_onehot,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   cnt_clr,
  output logic [OUT_W*CNT_W-1:0] hit_cnt
);
  import decoder_pkg::*;
  logic             full, empty, push, pop;
  logic [IDX_W-1:0] head;
  // Ready comes from occupancy alone so a full buffer never accepts on a same-cycle pop.
  assign in_ready   = !full && !rst;
  assign out_valid  = !empty;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_onehot = out_valid ? OUT_W'(onehot(32'(head))) : '0;
  fifo2_sync #(.W(IDX_W)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (in_idx),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  for (genvar i = 0; i < OUT_W; i++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = cnt_clr ? '0 : (pop && out_onehot[i] && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
    assign hit_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end
endmodule
